// File: rtl/regfile_if.sv
// Register-file bus: writeback write port, two decode read ports and the
// pending-load scoreboard signals. The decode/writeback side uses the master
// modport; the register file uses the slave modport.
interface regfile_if #(
    parameter int DATA_W = 32
);
    logic              we;
    logic [4:0]        waddr;
    logic [DATA_W-1:0] wdata;
    logic [4:0]        raddr1;
    logic [DATA_W-1:0] rdata1;
    logic [4:0]        raddr2;
    logic [DATA_W-1:0] rdata2;
    logic              pend_set;
    logic [4:0]        pend_addr;
    logic              busy1;
    logic              busy2;
    logic [31:0]       pending;

    modport master (
        output we, waddr, wdata,
        output raddr1, raddr2,
        output pend_set, pend_addr,
        input  rdata1, rdata2,
        input  busy1, busy2,
        input  pending
    );

    modport slave (
        input  we, waddr, wdata,
        input  raddr1, raddr2,
        input  pend_set, pend_addr,
        output rdata1, rdata2,
        output busy1, busy2,
        output pending
    );
endinterface

// File: rtl/regfile.sv
// MIPS general-purpose register file: 32 x DATA_W registers, one synchronous
// write port, two combinational read ports, $0 hardwired to zero, plus a
// pending-load scoreboard that flags reads of registers still awaiting a
// load result.
// Optional feature: define REGFILE_BYPASS_EN to forward same-cycle write
// data to the read ports and mask the matching busy flag.
module regfile #(
    parameter int DATA_W = 32
) (
    input  logic     clk,
    input  logic     rst,      // asynchronous, active-low
    regfile_if.slave bus
);

    logic [DATA_W-1:0] regs_q [32];
    logic [DATA_W-1:0] regs_d [32];
    logic [31:0]       pend_q;
    logic [31:0]       pend_d;

    logic [31:0]       pend_set_vec;
    logic [31:0]       pend_clr_vec;
    logic              hit1;
    logic              hit2;
    logic [DATA_W-1:0] rdata1;
    logic [DATA_W-1:0] rdata2;
    logic              busy1;
    logic              busy2;

    // Next register contents: a write to any index but 0 replaces the entry.
    always_comb begin
        regs_d = regs_q;
        if (bus.we && (bus.waddr != 5'd0)) begin
            regs_d[bus.waddr] = bus.wdata;
        end
    end

    // Scoreboard next state: set beats clear so a load issued while the
    // previous load to the same register retires keeps the register pending.
    always_comb begin
        pend_set_vec = '0;
        pend_clr_vec = '0;
        if (bus.pend_set) begin
            pend_set_vec[bus.pend_addr] = 1'b1;
        end
        if (bus.we) begin
            pend_clr_vec[bus.waddr] = 1'b1;
        end
        pend_d    = (pend_q & ~pend_clr_vec) | pend_set_vec;
        pend_d[0] = 1'b0;
    end

    // State registers; reset wipes both the register array and scoreboard.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
            pend_q <= '0;
        end else begin
            regs_q <= regs_d;
            pend_q <= pend_d;
        end
    end

    // Forwarding hits: a same-cycle write to a nonzero index being read.
    always_comb begin
`ifdef REGFILE_BYPASS_EN
        hit1 = bus.we && (bus.waddr == bus.raddr1) && (bus.raddr1 != 5'd0);
        hit2 = bus.we && (bus.waddr == bus.raddr2) && (bus.raddr2 != 5'd0);
`else
        hit1 = 1'b0;
        hit2 = 1'b0;
`endif
    end

    // Read port 1: index 0 and an asserted reset both read zero.
    always_comb begin
        rdata1 = '0;
        busy1  = 1'b0;
        if (rst && (bus.raddr1 != 5'd0)) begin
            rdata1 = hit1 ? bus.wdata : regs_q[bus.raddr1];
            busy1  = pend_q[bus.raddr1] && !hit1;
        end
    end

    // Read port 2: identical to port 1, fully independent.
    always_comb begin
        rdata2 = '0;
        busy2  = 1'b0;
        if (rst && (bus.raddr2 != 5'd0)) begin
            rdata2 = hit2 ? bus.wdata : regs_q[bus.raddr2];
            busy2  = pend_q[bus.raddr2] && !hit2;
        end
    end

    assign bus.rdata1  = rdata1;
    assign bus.rdata2  = rdata2;
    assign bus.busy1   = busy1;
    assign bus.busy2   = busy2;
    assign bus.pending = pend_q;

endmodule

// File: tb/tb_regfile.sv
// Directed bench for regfile: reset, $0 protection, dual-port readback,
// same-cycle write/read, and scoreboard set/clear priority.
module tb_regfile;

    localparam int DATA_W = 32;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    regfile_if #(.DATA_W(DATA_W)) bus ();

    regfile #(.DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.we        = 1'b0;
        bus.waddr     = 5'd0;
        bus.wdata     = '0;
        bus.pend_set  = 1'b0;
        bus.pend_addr = 5'd0;
    endtask

    initial begin
        logic bypass;
`ifdef REGFILE_BYPASS_EN
        bypass = 1'b1;
`else
        bypass = 1'b0;
`endif
        checks = 0;
        errors = 0;
        rst    = 1'b0;
        idle();
        bus.raddr1 = 5'd0;
        bus.raddr2 = 5'd0;

        // Reset state
        tick();
        tick();
        chk("rst_pending", bus.pending, 0);
        bus.raddr1 = 5'd5;
        bus.raddr2 = 5'd6;
        #1;
        chk("rst_rdata1", bus.rdata1, 0);
        chk("rst_busy2", bus.busy2, 0);
        rst = 1'b1;

        // Write r5 and mark r6 pending, then reset mid-cycle
        bus.we = 1'b1; bus.waddr = 5'd5; bus.wdata = 32'hDEADBEEF;
        bus.pend_set = 1'b1; bus.pend_addr = 5'd6;
        tick();
        idle();
        #1;
        chk("wr_r5", bus.rdata1, 32'hDEADBEEF);
        chk("pend_r6", bus.pending, 32'h0000_0040);
        chk("busy2_r6", bus.busy2, 1);
        rst = 1'b0;
        #1;
        chk("midrst_rdata1", bus.rdata1, 0);
        chk("midrst_pending", bus.pending, 0);
        chk("midrst_busy2", bus.busy2, 0);
        #1;
        rst = 1'b1;

        // $0 protection
        bus.we = 1'b1; bus.waddr = 5'd0; bus.wdata = 32'hFFFFFFFF;
        bus.pend_set = 1'b1; bus.pend_addr = 5'd0;
        bus.raddr1 = 5'd0;
        #1;
        chk("r0_comb", bus.rdata1, 0);
        tick();
        idle();
        #1;
        chk("r0_rdata1", bus.rdata1, 0);
        chk("r0_pending", bus.pending, 0);
        chk("r0_busy1", bus.busy1, 0);

        // Dual-port readback
        bus.we = 1'b1; bus.waddr = 5'd3; bus.wdata = 32'h12345678;
        tick();
        bus.waddr = 5'd31; bus.wdata = 32'hA5A5A5A5;
        tick();
        idle();
        bus.raddr1 = 5'd3;
        bus.raddr2 = 5'd31;
        #1;
        chk("dp_r3", bus.rdata1, 32'h12345678);
        chk("dp_r31", bus.rdata2, 32'hA5A5A5A5);
        bus.raddr1 = 5'd31;
        #1;
        chk("same_rd1", bus.rdata1, 32'hA5A5A5A5);
        chk("same_rd2", bus.rdata2, 32'hA5A5A5A5);

        // we=0 leaves contents unchanged
        bus.waddr = 5'd3; bus.wdata = 32'h0;
        tick();
        bus.raddr1 = 5'd3;
        #1;
        chk("we0_r3", bus.rdata1, 32'h12345678);

        // Same-cycle write and read of r7
        bus.we = 1'b1; bus.waddr = 5'd7; bus.wdata = 32'h1;
        tick();
        bus.wdata = 32'h2;
        bus.raddr1 = 5'd7;
        #1;
        chk("r7_same", bus.rdata1, bypass ? 32'h2 : 32'h1);
        tick();
        idle();
        #1;
        chk("r7_next", bus.rdata1, 32'h2);

        // Scoreboard set, set-wins, busy with same-cycle write
        bus.pend_set = 1'b1; bus.pend_addr = 5'd9;
        bus.raddr2 = 5'd9;
        #1;
        chk("busy2_before", bus.busy2, 0);
        tick();
        idle();
        #1;
        chk("busy2_r9", bus.busy2, 1);
        chk("pend_r9", bus.pending, 32'h0000_0200);
        bus.we = 1'b1; bus.waddr = 5'd9; bus.wdata = 32'h99;
        bus.pend_set = 1'b1; bus.pend_addr = 5'd9;
        tick();
        idle();
        #1;
        chk("setwins_r9", bus.pending[9], 1);
        bus.we = 1'b1; bus.waddr = 5'd9; bus.wdata = 32'hAB;
        bus.raddr1 = 5'd9;
        #1;
        chk("busy1_samecyc", bus.busy1, bypass ? 1'b0 : 1'b1);
        chk("rd1_samecyc", bus.rdata1, bypass ? 32'hAB : 32'h99);
        tick();
        idle();
        #1;
        chk("busy1_after", bus.busy1, 0);
        chk("pend_clr_r9", bus.pending, 0);
        chk("rd1_r9", bus.rdata1, 32'hAB);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
